decoder_3_8_pulse: RTL

Registered 3-to-8 one-hot decoder with a valid/ready input handshake and timed output pulses. It is the output-side counterpart of the 8-to-3 encoder: it takes a 3-bit code and drives the matching one-hot line for a fixed number of cycles. It then forces a quiet gap before the next code is accepted. It sits between control logic issuing channel/line indices and eight downstream select/strobe lines.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_3_8_pulse_hold_timer.sv | 46 ++++
 rtl/decoder_3_8_pulse.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types and constants for the 3-to-8 pulse decoder
//
// Purpose: state encoding, datapath widths and the code-to-one-hot helper
// used by decoder_3_8_pulse and hold_timer.
// Ports:   none (package).

package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

  function automatic logic [ONEHOT_W-1:0] decode_code(input logic [CODE_W-1:0] code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/decoder_3_8_pulse_hold_timer.sv
// rtl/decoder_3_8_pulse_hold_timer.sv - loadable down-counter timing the hold and gap phases
//
// Purpose: 8-bit down-counter shared by the DRIVE and GAP phases. A load
//          takes priority over a decrement; the counter never wraps below 0.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (counter -> 0)
//   load     in   load load_val this edge
//   load_val in   value to load
//   dec      in   decrement this edge (ignored when already zero)
//   zero     out  counter currently holds 0 (decoded from the flop)

module hold_timer
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_3_8_pulse.sv
// rtl/decoder_3_8_pulse.sv - registered 3-to-8 decoder emitting timed one-hot pulses
//
// Purpose: accepts a 3-bit code on a valid/ready handshake, drives the
//          matching one-hot line for HOLD_CYCLES cycles, then holds all
//          lines low for GAP_CYCLES cycles before accepting the next code.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   code_in     in   [2:0] index to decode, sampled on accept
//   code_valid  in   code_in is valid
//   code_ready  out  a code can be accepted this cycle
//   onehot_out  out  [7:0] one-hot decode of the latched code, or zero
//   busy        out  pulse or gap in progress
//   done        out  one-cycle pulse marking the end of each hold phase

module decoder_3_8_pulse
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   code_in,
  input  logic                code_valid,
  output logic                code_ready,
  output logic [ONEHOT_W-1:0] onehot_out,
  output logic                busy,
  output logic                done
);

  // Counter reload values: the phase lasts (value + 1) cycles.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  dec_state_t          state_q, state_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ONEHOT_W-1:0] onehot_q, onehot_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_dec;
  logic                tmr_zero;
  logic                accept;

  // ready_q is a flop, so the handshake has no combinational path to outputs.
  assign accept = code_valid && ready_q;

  hold_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    onehot_d = onehot_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = HOLD_LOAD;
    tmr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        // Also where code_ready first rises after reset release.
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        onehot_d = '0;
        if (accept) begin
          onehot_d = decode_code(code_in);
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
          state_d  = DRIVE;
        end
      end

      DRIVE: begin
        if (tmr_zero) begin
          onehot_d = '0;
          done_d   = 1'b1;
          if (HAS_GAP) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = GAP;
          end else begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      GAP: begin
        onehot_d = '0;
        if (tmr_zero) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      onehot_q <= onehot_d;
    end
  end

  assign code_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign onehot_out = onehot_q;

endmodule
